aes128_encrypt_iter: RTL and testbench

Iterative AES-128 encryption core that sits directly downstream of the key-expansion block. It consumes the eleven round keys K0..K10 produced by `GenRoundKeys` and encrypts one 128-bit block using one cipher round per clock. It accepts a block on a `start` pulse and returns the ciphertext with a one-cycle `done` pulse. It is the first sequential datapath stage of the cipher.

---
 rtl/aes128_encrypt_iter.sv | 203 ++++++++++++++++++++
 tb/tb_aes128_encrypt_iter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_iter.sv
// -----------------------------------------------------------------------------
// aes128_encrypt_iter
//
// Iterative AES-128 encryption core. It executes one cipher round per clock
// using round keys K0..K10 supplied by the key-expansion block. A block is
// accepted on a start pulse in IDLE, and ten edges later the ciphertext is
// presented with a one-cycle done pulse.
//
// Ports:
//   clk         in   1    rising-edge clock
//   rst         in   1    synchronous, active-high reset (top priority)
//   start       in   1    encrypt request, sampled only while idle
//   plaintext   in   128  input block, FIPS-197 byte order (byte 0 = [127:120])
//   K0..K10     in   128  round keys, held stable while busy
//   busy        out  1    a block is in flight
//   done        out  1    one-cycle pulse, ciphertext valid in that cycle
//   ciphertext  out  128  result register, held until the next done
//
// Also contains aes_sbox, the combinational byte S-box (GF(2^8) inverse
// followed by the affine transform).
// -----------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  logic [7:0] inv_b;

  assign inv_b    = gf_inv(in_byte);
  assign out_byte = inv_b
                  ^ {inv_b[6:0], inv_b[7]}
                  ^ {inv_b[5:0], inv_b[7:6]}
                  ^ {inv_b[4:0], inv_b[7:5]}
                  ^ {inv_b[3:0], inv_b[7:4]}
                  ^ 8'h63;

endmodule

module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  input  logic [127:0] K0,
  input  logic [127:0] K1,
  input  logic [127:0] K2,
  input  logic [127:0] K3,
  input  logic [127:0] K4,
  input  logic [127:0] K5,
  input  logic [127:0] K6,
  input  logic [127:0] K7,
  input  logic [127:0] K8,
  input  logic [127:0] K9,
  input  logic [127:0] K10,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q;
  logic [127:0] ciphertext_q;
  logic         done_q;

  logic [7:0]   s_bytes  [16];
  logic [7:0]   sb_bytes [16];
  logic [7:0]   sr_bytes [16];
  logic [7:0]   mc_bytes [16];
  logic [127:0] sr_vec;
  logic [127:0] mc_vec;
  logic [127:0] round_key;
  logic [127:0] state_d;
  logic [127:0] ciphertext_d;
  logic         final_round;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows. Byte index is row + 4*col; row r is rotated
  // left by r columns, so output (r,c) takes input (r,(c+r) mod 4).
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL + ROW) % 4);

      assign s_bytes[gi] = state_q[127-8*gi -: 8];

      aes_sbox u_sbox (
        .in_byte  (s_bytes[gi]),
        .out_byte (sb_bytes[gi])
      );

      assign sr_bytes[gi]           = sb_bytes[SRC];
      assign sr_vec[127-8*gi -: 8]  = sr_bytes[gi];
      assign mc_vec[127-8*gi -: 8]  = mc_bytes[gi];
    end
  endgenerate

  // MixColumns, one column per iteration; 3*a is xtime(a) ^ a.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
      logic [7:0] a0, a1, a2, a3;
      assign a0 = sr_bytes[4*gi + 0];
      assign a1 = sr_bytes[4*gi + 1];
      assign a2 = sr_bytes[4*gi + 2];
      assign a3 = sr_bytes[4*gi + 3];
      assign mc_bytes[4*gi + 0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign mc_bytes[4*gi + 1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign mc_bytes[4*gi + 2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign mc_bytes[4*gi + 3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // Round-key select; anything outside 1..9 uses K10 and is the last round,
  // so a corrupted counter still terminates the block.
  always_comb begin
    round_key = K10;
    case (rnd_q)
      4'd1:    round_key = K1;
      4'd2:    round_key = K2;
      4'd3:    round_key = K3;
      4'd4:    round_key = K4;
      4'd5:    round_key = K5;
      4'd6:    round_key = K6;
      4'd7:    round_key = K7;
      4'd8:    round_key = K8;
      4'd9:    round_key = K9;
      default: round_key = K10;
    endcase
  end

  assign final_round  = !((rnd_q >= 4'd1) && (rnd_q <= 4'd9));
  assign state_d      = mc_vec ^ round_key;
  assign ciphertext_d = sr_vec ^ round_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      rnd_q        <= 4'd0;
      state_q      <= 128'd0;
      ciphertext_q <= 128'd0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= plaintext ^ K0;
            rnd_q   <= 4'd1;
            fsm_q   <= RUN;
          end
        end
        RUN: begin
          if (final_round) begin
            ciphertext_q <= ciphertext_d;
            done_q       <= 1'b1;
            fsm_q        <= IDLE;
          end else begin
            state_q <= state_d;
            rnd_q   <= rnd_q + 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign busy       = (fsm_q == RUN);
  assign done       = done_q;
  assign ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
module tb_aes128_encrypt_iter;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] rk [11];
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  aes128_encrypt_iter dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .K0         (rk[0]),
    .K1         (rk[1]),
    .K2         (rk[2]),
    .K3         (rk[3]),
    .K4         (rk[4]),
    .K5         (rk[5]),
    .K6         (rk[6]),
    .K7         (rk[7]),
    .K8         (rk[8]),
    .K9         (rk[9]),
    .K10        (rk[10]),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ST1_B = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    logic [7:0] bb;
    acc = 8'h00;
    aa  = a;
    bb  = b;
    while (bb != 8'h00) begin
      if (bb[0]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return acc;
  endfunction

  // S-box table generated by walking the multiplicative group with generator 3.
  task automatic build_sbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
        tmp[31:24] = tmp[31:24] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [7:0] mix_coef(input int k);
    case (k)
      0:       return 8'h02;
      1:       return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] v;
    v = pt ^ rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[v[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row + 4*c] = s[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            s[row + 4*c] = 8'h00;
            for (int j = 0; j < 4; j++)
              s[row + 4*c] = s[row + 4*c] ^ gmul(mix_coef((j - row + 4) % 4), t[j + 4*c]);
          end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
      v = v ^ rk[r];
    end
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  // All driver activity happens 1 time unit after a rising edge.
  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [127:0] pt, input logic [127:0] exp, output int e0);
    exp_t e;
    plaintext = pt;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    e0        = cyc;
    e.ct      = exp;
    e.due     = cyc + 10;
    sb_q.push_back(e);
  endtask

  task automatic stray_start();
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with ct=%h expected no done (cycle %0d)", ciphertext, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ciphertext", ciphertext, e.ct);
        check("done_cycle", 128'(cyc), 128'(e.due));
        $display("txn: ct=%h expected=%h cycle=%0d due=%0d", ciphertext, e.ct, cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    int e1;
    int gap;
    int k;
    logic [127:0] key;
    logic [127:0] pt;

    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    for (int i = 0; i < 11; i++) rk[i] = '0;
    build_sbox();

    // Reset state, including a start pulse that must be ignored under reset.
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_done", 128'(done), 128'd0);
    check("reset_ciphertext", ciphertext, 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_busy", 128'(busy), 128'd0);

    // App. B vector, plus first-round state.
    load_key(KEY_B);
    issue(PT_B, CT_B, e0);
    check("busy_after_E0", 128'(busy), 128'd1);
    wait_until(e0 + 1);
    check("state_after_E1", dut.state_q, ST1_B);
    wait_until(e0 + 12);

    // App. C.1 vector and result hold.
    load_key(KEY_C);
    issue(PT_C, CT_C, e0);
    wait_until(e0 + 10);
    for (int i = 0; i < 20; i++) begin
      wait_until(cyc + 1);
      check("ciphertext_hold", ciphertext, CT_C);
      check("done_low_idle", 128'(done), 128'd0);
    end

    // Start during busy must be dropped.
    load_key(KEY_B);
    issue(PT_B, CT_B, e0);
    wait_until(e0 + 3);
    stray_start();
    wait_until(e0 + 11);
    check("busy_after_dropped_start", 128'(busy), 128'd0);
    wait_until(e0 + 25);
    check("scoreboard_empty_after_drop", 128'(sb_q.size()), 128'd0);

    // Back-to-back: start in the done cycle.
    issue(PT_B, CT_B, e0);
    wait_until(e0 + 9);
    check("busy_before_done", 128'(busy), 128'd1);
    wait_until(e0 + 10);
    check("busy_in_done_cycle", 128'(busy), 128'd0);
    check("done_in_done_cycle", 128'(done), 128'd1);
    load_key(KEY_C);
    issue(PT_C, CT_C, e1);
    check("busy_after_E11", 128'(busy), 128'd1);
    wait_until(e0 + 23);

    // Reset mid-operation at E5; the aborted block must never complete.
    load_key(KEY_B);
    issue(PT_B, CT_B, e0);
    void'(sb_q.pop_back());
    wait_until(e0 + 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_done", 128'(done), 128'd0);
    check("midrst_ciphertext", ciphertext, 128'd0);
    wait_until(cyc + 15);
    issue(PT_B, CT_B, e0);
    wait_until(e0 + 12);

    // Randomized blocks against the reference model, with stray starts and
    // random gaps (gap 0 issues the next block in the done cycle).
    for (int n = 0; n < 10; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      issue(pt, aes_ref(pt), e0);
      k = $urandom_range(1, 7);
      wait_until(e0 + k);
      stray_start();
      gap = $urandom_range(0, 3);
      wait_until(e0 + 10 + gap);
    end

    wait_until(cyc + 15);
    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
